// File: rtl/cic_pkg.sv
// cic_pkg
// Shared constants and helpers for the stereo PDM CIC decimator.
//   MAX_ORDER / MAX_DIFF_DELAY : supported limits for the stage count and
//                                comb differential delay
//   PDM_POS / PDM_NEG          : values a PDM bit maps to before integration
//   cic_acc_width()            : minimum accumulator width that keeps the
//                                modular CIC arithmetic exact for a given
//                                order, decimation rate and differential delay
package cic_pkg;

    localparam int MAX_ORDER      = 6;
    localparam int MAX_DIFF_DELAY = 2;

    // A PDM '1' contributes +1 and a '0' contributes -1 (sign-extended).
    localparam int PDM_POS = 1;
    localparam int PDM_NEG = -1;

    // Hogenauer bit growth: ORDER * ceil(log2(R*M)) plus one sign bit.
    function automatic int cic_acc_width(input int order, input int rate, input int diff_delay);
        return order * $clog2(rate * diff_delay) + 1;
    endfunction

endpackage

// File: rtl/cic_channel.sv
// cic_channel
// One channel of the CIC decimator: ORDER integrators running at the PDM
// bit rate followed by an ORDER-stage comb pipeline run once per frame.
// Ports:
//   clk, rst_n    : system clock, asynchronous active-low reset
//   clear         : synchronous clear of all channel state
//   sample_en     : one-cycle pulse when this channel's bit is captured
//   sample_bit    : captured PDM bit
//   strobe        : one-cycle decimation strobe; starts the comb pipeline
//   result        : output of the last comb stage (two's complement)
//   result_valid  : high for one cycle once the last comb stage has updated
module cic_channel
    import cic_pkg::*;
#(
    parameter int ORDER      = 4,
    parameter int DIFF_DELAY = 1,
    parameter int ACC_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             sample_en,
    input  logic             sample_bit,
    input  logic             strobe,
    output logic [ACC_W-1:0] result,
    output logic             result_valid
);

    logic [ACC_W-1:0] sample_val;
    logic [ACC_W-1:0] integ   [ORDER];
    logic [ACC_W-1:0] comb    [ORDER];
    logic [ACC_W-1:0] comb_in [ORDER];
    logic [ACC_W-1:0] dly     [ORDER][DIFF_DELAY];
    logic [ORDER-1:0] stage_vld;
    logic [ORDER-1:0] comb_go;

    assign sample_val = sample_bit ? ACC_W'(PDM_POS) : ACC_W'(PDM_NEG);

    // Integrator cascade. Every stage adds the previous stage's registered
    // value, so all stages advance together on one captured bit. Wrap-around
    // is intentional: the comb differences cancel it as long as ACC_W is wide
    // enough for the decimation rate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < ORDER; k++) integ[k] <= '0;
        end else if (clear) begin
            for (int k = 0; k < ORDER; k++) integ[k] <= '0;
        end else if (sample_en) begin
            integ[0] <= integ[0] + sample_val;
            for (int k = 1; k < ORDER; k++) integ[k] <= integ[k] + integ[k-1];
        end
    end

    // Stage k of the comb fires one cycle after stage k-1; stage 0 fires on
    // the cycle the strobe is high.
    always_comb begin
        comb_go    = '0;
        comb_go[0] = strobe;
        for (int k = 1; k < ORDER; k++) comb_go[k] = stage_vld[k-1];
    end

    always_comb begin
        comb_in[0] = integ[ORDER-1];
        for (int k = 1; k < ORDER; k++) comb_in[k] = comb[k-1];
    end

    // Valid token marching down the comb pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_vld <= '0;
        end else if (clear) begin
            stage_vld <= '0;
        end else begin
            stage_vld <= comb_go;
        end
    end

    // Comb stages: y = x - x[n-M], with an M-deep delay line per stage that
    // only shifts when the stage fires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < ORDER; k++) begin
                comb[k] <= '0;
                for (int j = 0; j < DIFF_DELAY; j++) dly[k][j] <= '0;
            end
        end else if (clear) begin
            for (int k = 0; k < ORDER; k++) begin
                comb[k] <= '0;
                for (int j = 0; j < DIFF_DELAY; j++) dly[k][j] <= '0;
            end
        end else begin
            for (int k = 0; k < ORDER; k++) begin
                if (comb_go[k]) begin
                    comb[k]   <= comb_in[k] - dly[k][DIFF_DELAY-1];
                    dly[k][0] <= comb_in[k];
                    for (int j = 1; j < DIFF_DELAY; j++) dly[k][j] <= dly[k][j-1];
                end
            end
        end
    end

    assign result       = comb[ORDER-1];
    assign result_valid = stage_vld[ORDER-1];

endmodule

// File: rtl/cic_pdm_stereo.sv
// cic_pdm_stereo
// Stereo PDM microphone front end: bit clock generation, left/right demux
// of the shared data line, per-channel CIC decimation and a valid/ready
// output with a sticky overrun flag.
// Ports:
//   clk, rst_n     : system clock, asynchronous active-low reset
//   enable         : run; low synchronously clears the datapath, clk_out=1
//   clk_div        : clk_out half-period is clk_div+1 clk cycles
//   dec_num        : decimation ratio R = dec_num+1 (taken at frame boundary)
//   clk_out        : bit clock to the microphones
//   data_in        : shared PDM data line
//   data_out_l/_r  : decimated left/right samples, two's complement
//   out_valid      : sample pair available
//   out_ready      : consumer accepts the pair
//   overrun        : sticky, a pair was overwritten before acceptance
//   overrun_clr    : clears overrun (a coincident new overrun wins)
module cic_pdm_stereo
    import cic_pkg::*;
#(
    parameter int ORDER      = 4,
    parameter int DIFF_DELAY = 1,
    parameter int ACC_W      = 32,
    parameter int DEC_W      = 8,
    parameter int DIV_W      = 16,
    // Highest decimation rate the accumulator width is sized for.
    parameter int MAX_RATE   = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [DIV_W-1:0] clk_div,
    input  logic [DEC_W-1:0] dec_num,
    output logic             clk_out,
    input  logic             data_in,
    output logic [ACC_W-1:0] data_out_l,
    output logic [ACC_W-1:0] data_out_r,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    input  logic             overrun_clr
);

    // Elaboration-time parameter checks.
    if (ORDER < 1 || ORDER > MAX_ORDER) begin : g_order_check
        $error("cic_pdm_stereo: ORDER must be in 1..%0d", MAX_ORDER);
    end
    if (DIFF_DELAY < 1 || DIFF_DELAY > MAX_DIFF_DELAY) begin : g_delay_check
        $error("cic_pdm_stereo: DIFF_DELAY must be in 1..%0d", MAX_DIFF_DELAY);
    end
    if (MAX_RATE < 1 || MAX_RATE > 2**DEC_W) begin : g_rate_check
        $error("cic_pdm_stereo: MAX_RATE must be reachable through dec_num");
    end
    if (cic_acc_width(ORDER, MAX_RATE, DIFF_DELAY) > ACC_W) begin : g_width_check
        $error("cic_pdm_stereo: ACC_W too small, need %0d",
               cic_acc_width(ORDER, MAX_RATE, DIFF_DELAY));
    end

    logic [DIV_W-1:0] div_cnt;
    logic             terminal;
    logic             left_cap;
    logic             right_cap;
    logic [DEC_W-1:0] dec_cnt;
    logic [DEC_W-1:0] dec_lat;
    logic             strobe;
    logic [ACC_W-1:0] res_l;
    logic [ACC_W-1:0] res_r;
    logic             vld_l;
    logic             vld_r;
    logic             load;

    // '>=' rather than '==' so lowering clk_div mid-count cannot strand the
    // counter above the new terminal value.
    assign terminal  = enable && (div_cnt >= clk_div);
    // clk_out low at the terminal count means it is about to rise: left bit.
    assign left_cap  = terminal && !clk_out;
    assign right_cap = terminal && clk_out;

    // Bit clock divider; clk_out idles high whenever the block is stopped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            clk_out <= 1'b1;
        end else if (!enable) begin
            div_cnt <= '0;
            clk_out <= 1'b1;
        end else if (terminal) begin
            div_cnt <= '0;
            clk_out <= !clk_out;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Frame counter shared by both channels, advanced on right captures so a
    // frame always closes after the right bit of its last bit-period. The
    // rate is only taken at the frame boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_cnt <= '0;
            dec_lat <= '0;
            strobe  <= 1'b0;
        end else if (!enable) begin
            dec_cnt <= '0;
            strobe  <= 1'b0;
        end else begin
            strobe <= 1'b0;
            if (right_cap) begin
                if (dec_cnt == dec_lat) begin
                    dec_cnt <= '0;
                    dec_lat <= dec_num;
                    strobe  <= 1'b1;
                end else begin
                    dec_cnt <= dec_cnt + 1'b1;
                end
            end
        end
    end

    cic_channel #(
        .ORDER      (ORDER),
        .DIFF_DELAY (DIFF_DELAY),
        .ACC_W      (ACC_W)
    ) u_left (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (!enable),
        .sample_en    (left_cap),
        .sample_bit   (data_in),
        .strobe       (strobe),
        .result       (res_l),
        .result_valid (vld_l)
    );

    cic_channel #(
        .ORDER      (ORDER),
        .DIFF_DELAY (DIFF_DELAY),
        .ACC_W      (ACC_W)
    ) u_right (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (!enable),
        .sample_en    (right_cap),
        .sample_bit   (data_in),
        .strobe       (strobe),
        .result       (res_r),
        .result_valid (vld_r)
    );

    assign load = vld_l && vld_r;

    // Output register and handshake. A load in the same cycle as a transfer
    // keeps out_valid high; a load onto an unaccepted pair flags overrun,
    // and that set takes priority over overrun_clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_l <= '0;
            data_out_r <= '0;
            out_valid  <= 1'b0;
            overrun    <= 1'b0;
        end else if (!enable) begin
            data_out_l <= '0;
            data_out_r <= '0;
            out_valid  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (load) begin
                data_out_l <= res_l;
                data_out_r <= res_r;
                out_valid  <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (load && out_valid && !out_ready) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cic_pdm_stereo.sv
// tb_cic_pdm_stereo
// Bench for cic_pdm_stereo: bit clock timing, steady-state gain for constant
// and alternating microphone patterns (including randomised levels/rates),
// overrun handling, asynchronous reset and enable clear.
module tb_cic_pdm_stereo;

    localparam int ORDER      = 4;
    localparam int M          = 1;
    localparam int ACC_W      = 32;
    localparam int DEC_W      = 8;
    localparam int DIV_W      = 16;
    localparam int WAIT_LIMIT = 4000;
    localparam int SKIP_PAIRS = 7;

    logic             clk;
    logic             rst_n;
    logic             enable;
    logic [DIV_W-1:0] clk_div;
    logic [DEC_W-1:0] dec_num;
    logic             clk_out;
    logic             data_in;
    logic [ACC_W-1:0] data_out_l;
    logic [ACC_W-1:0] data_out_r;
    logic             out_valid;
    logic             out_ready;
    logic             overrun;
    logic             overrun_clr;

    // Microphone model settings.
    logic left_alt;
    logic left_lvl;
    logic right_lvl;
    logic alt_bit;

    int tests_run;
    int tests_failed;
    bit timed_out;

    cic_pdm_stereo #(
        .ORDER      (ORDER),
        .DIFF_DELAY (M),
        .ACC_W      (ACC_W),
        .DEC_W      (DEC_W),
        .DIV_W      (DIV_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .clk_div     (clk_div),
        .dec_num     (dec_num),
        .clk_out     (clk_out),
        .data_in     (data_in),
        .data_out_l  (data_out_l),
        .data_out_r  (data_out_r),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Two microphones on one line: left drives while clk_out is low (it is
    // sampled as clk_out rises), right drives while clk_out is high.
    always @(posedge clk_out) alt_bit = ~alt_bit;

    always @* data_in = clk_out ? right_lvl : (left_alt ? alt_bit : left_lvl);

    // Reference gain: constant +/-1 input settles at +/-(R*M)^ORDER; an input
    // alternating every bit sits in the sinc null (R even) and settles at 0.
    function automatic logic [ACC_W-1:0] expected_level(input logic lvl, input logic alt, input int rate);
        longint gain;
        gain = 1;
        for (int i = 0; i < ORDER; i++) gain = gain * rate * M;
        if (alt) return '0;
        return lvl ? ACC_W'(gain) : ACC_W'(-gain);
    endfunction

    task automatic check_output(input string tag, input logic [ACC_W-1:0] observed,
                                input logic [ACC_W-1:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic check_bit(input string tag, input logic observed, input logic expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic alt, input logic l_lvl, input logic r_lvl, input int rate);
        left_alt  = alt;
        left_lvl  = l_lvl;
        right_lvl = r_lvl;
        dec_num   = DEC_W'(rate - 1);
    endtask

    // Waits (bounded) for a pair, samples it and lets out_ready=1 take it.
    task automatic get_pair(output logic [ACC_W-1:0] l, output logic [ACC_W-1:0] r);
        int waited;
        waited = 0;
        l = '0;
        r = '0;
        if (timed_out) return;
        while (out_valid !== 1'b1 && waited < WAIT_LIMIT) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= WAIT_LIMIT) begin
            timed_out = 1'b1;
            check_bit("pair_timeout", out_valid, 1'b1);
            return;
        end
        l = data_out_l;
        r = data_out_r;
        @(negedge clk);
    endtask

    task automatic skip_pairs(input int n);
        logic [ACC_W-1:0] l;
        logic [ACC_W-1:0] r;
        for (int i = 0; i < n; i++) get_pair(l, r);
    endtask

    task automatic count_edges_until(input logic level, output int count);
        count = 0;
        while (clk_out !== level && count < 200) begin
            @(posedge clk);
            #1;
            count++;
        end
    endtask

    task automatic wait_overrun();
        int waited;
        waited = 0;
        while (overrun !== 1'b1 && waited < WAIT_LIMIT) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= WAIT_LIMIT) begin
            timed_out = 1'b1;
            check_bit("overrun_timeout", overrun, 1'b1);
        end
    endtask

    initial begin
        logic [ACC_W-1:0] l;
        logic [ACC_W-1:0] r;
        int cnt;
        int rate;
        logic r_alt;
        logic r_l;
        logic r_r;

        tests_run    = 0;
        tests_failed = 0;
        timed_out    = 1'b0;
        alt_bit      = 1'b0;
        rst_n        = 1'b1;
        enable       = 1'b1;
        clk_div      = DIV_W'(24);
        out_ready    = 1'b1;
        overrun_clr  = 1'b0;
        apply_stimulus(1'b0, 1'b1, 1'b1, 16);
        #1 rst_n = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        check_bit("rst_clk_out", clk_out, 1'b1);
        check_bit("rst_out_valid", out_valid, 1'b0);
        check_bit("rst_overrun", overrun, 1'b0);
        check_output("rst_data_l", data_out_l, '0);
        check_output("rst_data_r", data_out_r, '0);

        // Bit clock: first fall 25 clk after release, then 25-clk half periods.
        rst_n = 1'b1;
        count_edges_until(1'b0, cnt);
        check_output("first_fall", ACC_W'(cnt), ACC_W'(25));
        count_edges_until(1'b1, cnt);
        check_output("high_to_rise", ACC_W'(cnt), ACC_W'(25));
        begin
            int half;
            count_edges_until(1'b0, half);
            check_output("period", ACC_W'(cnt + half), ACC_W'(50));
        end

        // Constant 1 on both channels, R=16.
        skip_pairs(SKIP_PAIRS);
        get_pair(l, r);
        check_output("ones_l", l, expected_level(1'b1, 1'b0, 16));
        check_output("ones_r", r, expected_level(1'b1, 1'b0, 16));
        check_output("ones_l_abs", l, 32'h0001_0000);

        // Faster bit clock from here on to keep the run short.
        clk_div = DIV_W'(6);

        // Left 1, right 0.
        apply_stimulus(1'b0, 1'b1, 1'b0, 16);
        skip_pairs(SKIP_PAIRS);
        get_pair(l, r);
        check_output("split_l", l, 32'h0001_0000);
        check_output("split_r", r, 32'hFFFF_0000);

        // Alternating left, right held 1.
        apply_stimulus(1'b1, 1'b0, 1'b1, 16);
        skip_pairs(SKIP_PAIRS);
        get_pair(l, r);
        check_output("alt_l", l, expected_level(1'b0, 1'b1, 16));
        check_output("alt_r", r, expected_level(1'b1, 1'b0, 16));

        // Randomised levels, patterns and rates.
        for (int it = 0; it < 3; it++) begin
            r_alt = 1'($urandom_range(0, 1));
            r_l   = 1'($urandom_range(0, 1));
            r_r   = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       rate = 4;
                1:       rate = 8;
                2:       rate = 16;
                default: rate = 32;
            endcase
            apply_stimulus(r_alt, r_l, r_r, rate);
            skip_pairs(SKIP_PAIRS);
            get_pair(l, r);
            check_output($sformatf("rand%0d_R%0d_l", it, rate), l, expected_level(r_l, r_alt, rate));
            check_output($sformatf("rand%0d_R%0d_r", it, rate), r, expected_level(r_r, 1'b0, rate));
        end

        // Overrun: stall across two strobes, clear, then accept.
        apply_stimulus(1'b0, 1'b1, 1'b1, 16);
        skip_pairs(SKIP_PAIRS);
        out_ready = 1'b0;
        cnt = 0;
        while (out_valid !== 1'b1 && cnt < WAIT_LIMIT) begin
            @(negedge clk);
            cnt++;
        end
        check_bit("first_pair_no_overrun", overrun, 1'b0);
        wait_overrun();
        check_bit("overrun_set", overrun, 1'b1);
        check_bit("overrun_valid_held", out_valid, 1'b1);
        check_output("overrun_data_l", data_out_l, expected_level(1'b1, 1'b0, 16));
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        check_bit("overrun_cleared", overrun, 1'b0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_bit("accept_clears_valid", out_valid, 1'b0);

        // Asynchronous reset mid-frame with outputs busy.
        wait_overrun();
        dec_num = DEC_W'(7);
        rst_n = 1'b0;
        #1;
        check_bit("async_rst_valid", out_valid, 1'b0);
        check_bit("async_rst_overrun", overrun, 1'b0);
        check_bit("async_rst_clk_out", clk_out, 1'b1);
        check_output("async_rst_data_l", data_out_l, '0);
        check_output("async_rst_data_r", data_out_r, '0);
        @(negedge clk);
        @(negedge clk);
        out_ready = 1'b1;
        rst_n = 1'b1;
        skip_pairs(SKIP_PAIRS);
        get_pair(l, r);
        check_output("r8_l", l, 32'd4096);
        check_output("r8_r", r, expected_level(1'b1, 1'b0, 8));

        // Enable low clears synchronously and parks clk_out high.
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_bit("disable_clk_out", clk_out, 1'b1);
        check_bit("disable_valid", out_valid, 1'b0);
        check_output("disable_data_l", data_out_l, '0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
